// File: rtl/pwm_pkg.sv
// Shared encodings and default sizing for the multi-channel PWM counter.
package pwm_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  typedef enum logic {
    MODE_UP     = 1'b0,
    MODE_UPDOWN = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair and the registered compare output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_xfer,
  input  logic [WIDTH-1:0] i_duty,
  input  logic [WIDTH-1:0] i_next_cntr,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_duty_sh;
  logic [WIDTH-1:0] r_duty_act;
  logic             r_pwm;
  logic [WIDTH-1:0] w_duty_next;

  // Compare against the duty that will be active after this edge.
  assign w_duty_next = i_xfer ? r_duty_sh : r_duty_act;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty_sh  <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_load) begin
        r_duty_sh <= i_duty;
      end
      if (i_xfer) begin
        r_duty_act <= r_duty_sh;
      end
      if (i_en) begin
        r_pwm <= (i_next_cntr < w_duty_next);
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_counter.sv
// Shared edge- or center-aligned counter driving CHANNELS PWM compares, with
// double-buffered period/mode/duty that swap in only at a period boundary.
module pwm_multi_counter
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_mode,
  input  logic [WIDTH-1:0]          i_period,
  input  logic [CHANNELS*WIDTH-1:0] i_duty,
  input  logic                      i_load,
  output logic [WIDTH-1:0]          o_cntr,
  output logic [CHANNELS-1:0]       o_pwm,
  output logic                      o_wrap,
  output logic                      o_pend
);

  logic [WIDTH-1:0] r_cntr;
  dir_e             r_dir;
  logic             r_wrap;
  logic             r_pend;
  mode_e            r_mode_sh;
  mode_e            r_mode_act;
  logic [WIDTH-1:0] r_period_sh;
  logic [WIDTH-1:0] r_period_act;

  logic [WIDTH-1:0] w_cntr_next;
  logic [WIDTH-1:0] w_cntr_inc;
  dir_e             w_dir_next;
  logic             w_boundary;
  logic             w_xfer;

  assign w_cntr_inc = r_cntr + WIDTH'(1);

  always_comb begin
    w_boundary  = 1'b0;
    w_cntr_next = r_cntr;
    w_dir_next  = r_dir;
    if (i_en) begin
      if (r_period_act == '0) begin
        w_boundary  = 1'b1;
        w_cntr_next = '0;
        w_dir_next  = DIR_UP;
      end else if (r_mode_act == MODE_UP) begin
        w_dir_next = DIR_UP;
        if (r_cntr == r_period_act) begin
          w_boundary  = 1'b1;
          w_cntr_next = '0;
        end else begin
          w_cntr_next = w_cntr_inc;
        end
      end else if (r_dir == DIR_UP) begin
        // Turn around on the edge that reaches the top, so P itself is counted down.
        w_cntr_next = w_cntr_inc;
        if (w_cntr_inc == r_period_act) begin
          w_dir_next = DIR_DOWN;
        end
      end else if (r_cntr == WIDTH'(1)) begin
        w_boundary  = 1'b1;
        w_cntr_next = '0;
        w_dir_next  = DIR_UP;
      end else begin
        w_cntr_next = r_cntr - WIDTH'(1);
      end
    end
  end

  assign w_xfer = w_boundary & r_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cntr       <= '0;
      r_dir        <= DIR_UP;
      r_wrap       <= 1'b0;
      r_pend       <= 1'b0;
      r_mode_sh    <= MODE_UP;
      r_mode_act   <= MODE_UP;
      r_period_sh  <= '1;
      r_period_act <= '1;
    end else begin
      r_cntr <= w_cntr_next;
      r_dir  <= w_dir_next;
      r_wrap <= w_boundary;
      if (w_xfer) begin
        r_mode_act   <= r_mode_sh;
        r_period_act <= r_period_sh;
      end
      if (i_load) begin
        r_mode_sh   <= mode_e'(i_mode);
        r_period_sh <= i_period;
      end
      // A load coinciding with a transfer refills the shadow, so pending stays set.
      if (i_load) begin
        r_pend <= 1'b1;
      end else if (w_xfer) begin
        r_pend <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_load     (i_load),
      .i_xfer     (w_xfer),
      .i_duty     (i_duty[g*WIDTH +: WIDTH]),
      .i_next_cntr(w_cntr_next),
      .o_pwm      (o_pwm[g])
    );
  end

  assign o_cntr = r_cntr;
  assign o_wrap = r_wrap;
  assign o_pend = r_pend;

endmodule

// File: tb/tb_pwm_multi_counter.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations, monitor compares.
module tb_pwm_multi_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned CH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic [W-1:0]  period;
  logic [CH*W-1:0] duty;
  logic          load;
  logic [W-1:0]  cntr;
  logic [CH-1:0] pwm;
  logic          wrap;
  logic          pend;

  typedef struct {
    int           cyc;
    logic [W-1:0] cntr;
    logic [1:0]   pwm;
    logic         wrap;
    logic         pend;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_asserts = 0;
  int   n_fail = 0;
  logic done = 1'b0;

  pwm_multi_counter #(
    .WIDTH   (W),
    .CHANNELS(CH)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_mode  (mode),
    .i_period(period),
    .i_duty  (duty),
    .i_load  (load),
    .o_cntr  (cntr),
    .o_pwm   (pwm),
    .o_wrap  (wrap),
    .o_pend  (pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int c, input int act, input int req);
    n_asserts++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, c, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whatever is due now.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) begin
        chk("missed_sample", e.cyc, cyc, e.cyc);
      end else begin
        chk("cntr", cyc, int'(cntr), int'(e.cntr));
        chk("pwm",  cyc, int'(pwm),  int'(e.pwm));
        chk("wrap", cyc, int'(wrap), int'(e.wrap));
        chk("pend", cyc, int'(pend), int'(e.pend));
      end
    end
    if (done || cyc > 2000) begin
      chk("queue_drained", cyc, q.size(), 0);
      chk("no_timeout", cyc, int'(cyc > 2000), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
    end
  end

  task automatic expect_out(input int c, input logic [1:0] p, input logic w, input logic pd);
    exp_t x;
    x.cyc  = cyc + 1;
    x.cntr = W'(c);
    x.pwm  = p;
    x.wrap = w;
    x.pend = pd;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; period = '0; duty = '0;
    expect_out(0, 2'b00, 0, 0); tick();
    expect_out(0, 2'b00, 0, 0); tick();

    // Default free-running 0..15 counter
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 15; k++) begin expect_out(k, 2'b00, 0, 0); tick(); end
    expect_out(0, 2'b00, 1, 0); tick();
    for (int k = 1; k <= 5; k++) begin expect_out(k, 2'b00, 0, 0); tick(); end

    // Load P=9, duty {7,3} at CNTR=5; applies at next wrap
    load = 1'b1; period = 4'd9; duty = {4'd7, 4'd3};
    expect_out(6, 2'b00, 0, 1); tick();
    load = 1'b0;
    for (int k = 7; k <= 15; k++) begin expect_out(k, 2'b00, 0, 1); tick(); end
    expect_out(0, 2'b11, 1, 0); tick();
    for (int k = 1; k <= 9; k++) begin expect_out(k, {k < 7, k < 3}, 0, 0); tick(); end
    expect_out(0, 2'b11, 1, 0); tick();

    // Duty {12,0}: channel 1 always high, channel 0 always low
    load = 1'b1; duty = {4'd12, 4'd0};
    expect_out(1, 2'b11, 0, 1); tick();
    load = 1'b0;
    for (int k = 2; k <= 9; k++) begin expect_out(k, {k < 7, k < 3}, 0, 1); tick(); end
    expect_out(0, 2'b10, 1, 0); tick();
    for (int k = 1; k <= 9; k++) begin expect_out(k, 2'b10, 0, 0); tick(); end

    // Load up-down P=5 on a boundary edge, then freeze for 3 cycles
    load = 1'b1; mode = 1'b1; period = 4'd5; duty = {4'd6, 4'd2};
    expect_out(0, 2'b10, 1, 1); tick();
    load = 1'b0; en = 1'b0;
    repeat (3) begin expect_out(0, 2'b10, 0, 1); tick(); end
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin expect_out(k, 2'b10, 0, 1); tick(); end
    expect_out(0, 2'b11, 1, 0); tick();
    repeat (2) begin
      for (int j = 1; j <= 9; j++) begin
        c = (j <= 5) ? j : 10 - j;
        expect_out(c, {1'b1, c < 2}, 0, 0); tick();
      end
      expect_out(0, 2'b11, 1, 0); tick();
    end

    // Back to up mode P=12, then leave a pending load and reset at CNTR=6
    load = 1'b1; mode = 1'b0; period = 4'd12; duty = {4'd8, 4'd4};
    expect_out(1, 2'b11, 0, 1); tick();
    load = 1'b0;
    for (int j = 2; j <= 9; j++) begin
      c = (j <= 5) ? j : 10 - j;
      expect_out(c, {1'b1, c < 2}, 0, 1); tick();
    end
    expect_out(0, 2'b11, 1, 0); tick();
    load = 1'b1; period = 4'd3; duty = {4'd1, 4'd1};
    expect_out(1, 2'b11, 0, 1); tick();
    load = 1'b0;
    for (int k = 2; k <= 6; k++) begin expect_out(k, {k < 8, k < 4}, 0, 1); tick(); end
    rst = 1'b1; load = 1'b1;
    expect_out(0, 2'b00, 0, 0); tick();
    rst = 1'b0; load = 1'b0;
    for (int k = 1; k <= 15; k++) begin expect_out(k, 2'b00, 0, 0); tick(); end
    expect_out(0, 2'b00, 1, 0); tick();

    // P=0: counter pinned at 0, every enabled edge wraps
    load = 1'b1; period = 4'd0; duty = {4'd1, 4'd0};
    expect_out(1, 2'b00, 0, 1); tick();
    load = 1'b0;
    for (int k = 2; k <= 15; k++) begin expect_out(k, 2'b00, 0, 1); tick(); end
    repeat (5) begin expect_out(0, 2'b10, 1, 0); tick(); end
    en = 1'b0;
    expect_out(0, 2'b10, 0, 0); tick();
    done = 1'b1;
  end

endmodule
